// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM shadow-compare block.
package pwm_pkg;

  localparam int PWM_W  = 8;
  localparam int DUTY_W = PWM_W + 1;
  localparam logic [PWM_W-1:0] ALL_ONES = '1;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } duty_state_t;

endpackage

// File: rtl/duty_shadow_reg.sv
// Duty handshake: accepts a new duty into a shadow register and commits it
// to duty_act only on a period boundary.
module duty_shadow_reg
  import pwm_pkg::*;
#(
  parameter int         W         = 8,
  parameter logic [W:0] INIT_DUTY = '0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bnd,
  input  logic [W:0] duty_in,
  input  logic       duty_valid,
  output logic       duty_ready,
  output logic [W:0] duty_act
);

  duty_state_t state_reg, state_next;
  logic [W:0]  shadow_reg, shadow_next;
  logic [W:0]  act_reg, act_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      shadow_reg <= '0;
      act_reg    <= INIT_DUTY;
    end else begin
      state_reg  <= state_next;
      shadow_reg <= shadow_next;
      act_reg    <= act_next;
    end
  end

  // A value accepted on a boundary cycle waits for the following boundary.
  always_comb begin
    state_next  = state_reg;
    shadow_next = shadow_reg;
    act_next    = act_reg;
    case (state_reg)
      IDLE: begin
        if (duty_valid) begin
          shadow_next = duty_in;
          state_next  = PENDING;
        end
      end
      PENDING: begin
        if (bnd) begin
          act_next   = shadow_reg;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    duty_ready = (state_reg == IDLE);
    duty_act   = act_reg;
  end

endmodule

// File: rtl/pwm_shadow_cmp.sv
// Registered PWM compare against a double-buffered duty, with a period tick
// marking the first count of each period.
module pwm_shadow_cmp
  import pwm_pkg::*;
#(
  parameter int         W          = 8,
  parameter bit         ACTIVE_LOW = 1'b0,
  parameter logic [W:0] INIT_DUTY  = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] cnt_in,
  input  logic [W-1:0] cnt_top,
  input  logic [W:0]   duty_in,
  input  logic         duty_valid,
  output logic         duty_ready,
  output logic         pwm_out,
  output logic         period_tick,
  output logic [W:0]   duty_act
);

  localparam logic [W-1:0] CNT_ONES = {W{1'b1}};

  logic bnd;
  logic level;

  // All-ones also ends a period so a lowered cnt_top below the count recovers.
  assign bnd   = (cnt_in == cnt_top) || (cnt_in == CNT_ONES);
  assign level = ({1'b0, cnt_in} < duty_act) ^ ACTIVE_LOW;

  duty_shadow_reg #(
    .W         (W),
    .INIT_DUTY (INIT_DUTY)
  ) u_shadow (
    .clk        (clk),
    .reset      (reset),
    .bnd        (bnd),
    .duty_in    (duty_in),
    .duty_valid (duty_valid),
    .duty_ready (duty_ready),
    .duty_act   (duty_act)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_out     <= ACTIVE_LOW;
      period_tick <= 1'b0;
    end else begin
      pwm_out     <= en ? level : ACTIVE_LOW;
      period_tick <= bnd && en;
    end
  end

endmodule

// File: tb/tb_pwm_shadow_cmp.sv
// Directed bench for pwm_shadow_cmp; a second instance checks the inverted polarity.
module tb_pwm_shadow_cmp;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [7:0] cnt_in;
  logic [7:0] cnt_top;
  logic [8:0] duty_in;
  logic       duty_valid;
  logic       duty_ready, pwm_out, period_tick;
  logic [8:0] duty_act;
  logic       duty_ready_n, pwm_out_n, period_tick_n;
  logic [8:0] duty_act_n;

  int checks = 0;
  int errors = 0;
  int cnt    = 0;
  int prev   = 0;
  int top    = 9;

  always #5 clk = ~clk;

  pwm_shadow_cmp #(.W(8), .ACTIVE_LOW(1'b0), .INIT_DUTY(9'd0)) dut (
    .clk(clk), .reset(reset), .en(en), .cnt_in(cnt_in), .cnt_top(cnt_top),
    .duty_in(duty_in), .duty_valid(duty_valid), .duty_ready(duty_ready),
    .pwm_out(pwm_out), .period_tick(period_tick), .duty_act(duty_act)
  );

  pwm_shadow_cmp #(.W(8), .ACTIVE_LOW(1'b1), .INIT_DUTY(9'd0)) dut_n (
    .clk(clk), .reset(reset), .en(en), .cnt_in(cnt_in), .cnt_top(cnt_top),
    .duty_in(duty_in), .duty_valid(duty_valid), .duty_ready(duty_ready_n),
    .pwm_out(pwm_out_n), .period_tick(period_tick_n), .duty_act(duty_act_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of the upstream counter model; cnt_in changes 1 time unit after the edge.
  task automatic adv();
    @(posedge clk);
    #1;
    prev = cnt;
    cnt  = (cnt == top || cnt == 255) ? 0 : cnt + 1;
    cnt_in = 8'(cnt);
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 300 && cnt != target; i++) adv();
    check("run_to", 32'(cnt), 32'(target));
  endtask

  task automatic send(input int d);
    duty_in    = 9'(d);
    duty_valid = 1'b1;
    adv();
    duty_valid = 1'b0;
  endtask

  initial begin
    int highs;
    int steps;
    int ticks;

    reset = 1'b1; en = 1'b1; cnt_in = 8'd0; cnt_top = 8'd9;
    duty_in = 9'd0; duty_valid = 1'b0;
    #12;
    check("rst_pwm", 32'(pwm_out), 32'd0);
    check("rst_pwm_n", 32'(pwm_out_n), 32'd1);
    check("rst_tick", 32'(period_tick), 32'd0);
    check("rst_ready", 32'(duty_ready), 32'd1);
    check("rst_act", 32'(duty_act), 32'd0);
    reset = 1'b0;
    $display("step: reset released");

    // Duty 0: output stays low, tick every 10 cycles on cnt_in == 0.
    ticks = 0;
    for (int i = 0; i < 30; i++) begin
      adv();
      check("idle_pwm", 32'(pwm_out), 32'd0);
      check("idle_tick", 32'(period_tick), 32'(cnt == 0));
      if (period_tick) ticks++;
    end
    check("idle_tick_count", 32'(ticks), 32'd3);
    $display("step: duty 0 idle periods");

    // Duty 3 accepted mid-period, takes effect after cnt_in = 9.
    run_to(4);
    send(3);
    check("d3_ready_drop", 32'(duty_ready), 32'd0);
    check("d3_act_hold", 32'(duty_act), 32'd0);
    run_to(0);
    check("d3_act_applied", 32'(duty_act), 32'd3);
    check("d3_ready_back", 32'(duty_ready), 32'd1);
    check("d3_first_pwm", 32'(pwm_out), 32'd0);
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      adv();
      check("d3_pwm", 32'(pwm_out), 32'(prev < 3));
      check("d3_pwm_n", 32'(pwm_out_n), 32'(prev >= 3));
      if (pwm_out) highs++;
    end
    check("d3_high_count", 32'(highs), 32'd3);
    $display("step: duty 3 pattern");

    // Duty 10 > top: always active; then duty 0: always inactive.
    send(10);
    run_to(0);
    for (int i = 0; i < 10; i++) begin
      adv();
      check("d10_pwm", 32'(pwm_out), 32'd1);
      check("d10_pwm_n", 32'(pwm_out_n), 32'd0);
    end
    send(0);
    run_to(0);
    for (int i = 0; i < 10; i++) begin
      adv();
      check("d0_pwm", 32'(pwm_out), 32'd0);
      check("d0_pwm_n", 32'(pwm_out_n), 32'd1);
    end
    $display("step: duty 10 and duty 0");

    // Accept on the boundary cycle applies at the next boundary; PENDING ignores valid.
    run_to(9);
    send(5);
    check("coll_no_bypass", 32'(duty_act), 32'd0);
    check("coll_pending", 32'(duty_ready), 32'd0);
    run_to(3);
    send(7);
    check("coll_ignored_act", 32'(duty_act), 32'd0);
    run_to(0);
    check("coll_applied", 32'(duty_act), 32'd5);
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      adv();
      if (pwm_out) highs++;
    end
    check("coll_high_count", 32'(highs), 32'd5);
    $display("step: boundary collisions");

    // Lower cnt_top below the running count: period ends at all-ones.
    top = 200; cnt_top = 8'd200;
    run_to(120);
    top = 50; cnt_top = 8'd50;
    steps = 0; ticks = 0;
    while (cnt != 0 && steps < 300) begin
      adv();
      steps++;
      if (period_tick) ticks++;
    end
    check("wrap_steps", 32'(steps), 32'd136);
    check("wrap_ticks", 32'(ticks), 32'd1);
    check("wrap_tick_now", 32'(period_tick), 32'd1);
    steps = 0;
    do begin
      adv();
      steps++;
    end while (!period_tick && steps < 300);
    check("period_51", 32'(steps), 32'd51);
    $display("step: cnt_top lowered");

    // en low for 5 cycles across the boundary while a duty is pending.
    top = 9; cnt_top = 8'd9;
    run_to(2);
    send(8);
    run_to(5);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      adv();
      check("en_pwm", 32'(pwm_out), 32'd0);
      check("en_pwm_n", 32'(pwm_out_n), 32'd1);
      check("en_tick", 32'(period_tick), 32'd0);
    end
    check("en_applied", 32'(duty_act), 32'd8);
    en = 1'b1;
    adv();
    check("en_resume", 32'(pwm_out), 32'd1);
    $display("step: enable gating");

    // Asynchronous reset while PENDING.
    send(2);
    check("pre_rst_pending", 32'(duty_ready), 32'd0);
    #2 reset = 1'b1;
    #1;
    check("arst_ready", 32'(duty_ready), 32'd1);
    check("arst_act", 32'(duty_act), 32'd0);
    check("arst_pwm", 32'(pwm_out), 32'd0);
    check("arst_pwm_n", 32'(pwm_out_n), 32'd1);
    #2 reset = 1'b0;
    run_to(0);
    check("arst_discarded", 32'(duty_act), 32'd0);
    $display("step: async reset while pending");

    // cnt_top = 0: boundary every cycle.
    top = 0; cnt_top = 8'd0;
    send(4);
    check("top0_accept", 32'(duty_act), 32'd0);
    adv();
    check("top0_applied", 32'(duty_act), 32'd4);
    check("top0_tick", 32'(period_tick), 32'd1);
    adv();
    check("top0_pwm", 32'(pwm_out), 32'd1);
    check("top0_tick2", 32'(period_tick), 32'd1);
    $display("step: cnt_top zero");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
